// File: rtl/grant_burst_scheduler.sv
// grant_burst_scheduler
// Shares one downstream resource among NREQ requesters for a burst of
// burst_len grant/ack pairs. Grants are issued round-robin, one at a time,
// each waiting for its ack (or a timeout) before the next is issued.
//
// Ports:
//   clk        : single clock, posedge
//   rst        : synchronous active-high reset
//   start      : launch a burst (sampled only in IDLE)
//   burst_len  : number of grant/ack pairs, latched on accepted start
//   req        : per-requester request levels (sampled only in ARB)
//   grant      : one-hot, one-cycle registered grant pulse
//   ack        : completion of the current granted transfer
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse, burst completed
//   error      : one-cycle pulse, ack timeout, burst aborted
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start
// ARB    | choosing the next requester round-robin from ptr
// WAIT   | grant outstanding; first cycle is the grant cycle, then ack
// DONE   | done pulse, back to IDLE
// ERR    | error pulse after ack timeout, back to IDLE
module grant_burst_scheduler #(
    parameter int NREQ    = 4,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  grant,
    input  logic             ack,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam int PTR_W = $clog2(NREQ);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic               found;
    logic [PTR_W-1:0]   winner;
    logic [PTR_W-1:0]   idx_w;
    logic [CNT_W:0]     cnt_inc;
    logic [TMR_W-1:0]   timer_inc;

    // Round-robin search: first requester at or after ptr, wrapping.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx_w  = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx_w = PTR_W'((int'(ptr_q) + i) % NREQ);
            if (!found && req[idx_w]) begin
                found  = 1'b1;
                winner = idx_w;
            end
        end
    end

    // One extra bit so cnt+1 can never wrap before comparing against len.
    assign cnt_inc   = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
    assign timer_inc = timer_q + TMR_W'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        ptr_d   = ptr_q;
        grant_d = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    cnt_d   = '0;
                    timer_d = '0;
                    state_d = (burst_len == '0) ? S_DONE : S_ARB;
                end
            end
            S_ARB: begin
                if (found) begin
                    grant_d[winner] = 1'b1;
                    timer_d         = '0;
                    ptr_d           = (winner == PTR_W'(NREQ - 1)) ? '0 : winner + PTR_W'(1);
                    state_d         = S_WAIT;
                end
            end
            S_WAIT: begin
                // grant_q is high only during the grant cycle; ack is ignored there.
                if (grant_q == '0) begin
                    if (ack) begin
                        if (cnt_inc == {1'b0, len_q}) begin
                            state_d = S_DONE;
                        end else begin
                            cnt_d   = cnt_inc[CNT_W-1:0];
                            timer_d = '0;
                            state_d = S_ARB;
                        end
                    end else begin
                        timer_d = timer_inc;
                        if (timer_inc == TMR_W'(TIMEOUT)) begin
                            state_d = S_ERR;
                        end
                    end
                end
            end
            S_DONE: begin
                cnt_d   = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end
            S_ERR: begin
                cnt_d   = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
        error_d = (state_d == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign grant = grant_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign error = error_q;

endmodule

// File: tb/tb_grant_burst_scheduler.sv
// Directed testbench for grant_burst_scheduler (NREQ=4, CNT_W=4, TIMEOUT=15).
// Inputs are driven and outputs checked on the falling edge; a monitor
// samples shortly after each rising edge to count pulses and invariants.
module tb_grant_burst_scheduler;

    localparam int NREQ    = 4;
    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] burst_len;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  grant;
    logic             ack;
    logic             busy;
    logic             done;
    logic             error;

    always #5 clk = ~clk;

    grant_burst_scheduler #(
        .NREQ    (NREQ),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .burst_len (burst_len),
        .req       (req),
        .grant     (grant),
        .ack       (ack),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gcnt   = 0;
    int dcnt   = 0;
    int ecnt   = 0;
    int consec = 0;
    int both   = 0;
    logic prev_g = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(posedge clk);
        #2;
        if (|grant) gcnt++;
        if (|grant && prev_g) consec++;
        prev_g = |grant;
        if (done) dcnt++;
        if (error) ecnt++;
        if (done && error) both++;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic start_burst(input int len, output int t0);
        start     = 1'b1;
        burst_len = len[CNT_W-1:0];
        t0        = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_grant(input string tag, output logic [NREQ-1:0] g, output int gc);
        g  = '0;
        gc = -1;
        for (int k = 0; k < 40; k++) begin
            if (grant != '0) begin
                g  = grant;
                gc = cyc;
                break;
            end
            @(negedge clk);
        end
        check_val({tag, "_seen"}, 32'(gc >= 0), 1);
    endtask

    // Wait for a grant, then ack in the cycle after the grant cycle.
    task automatic serve(input string tag, output logic [NREQ-1:0] g, output int gc);
        wait_grant(tag, g, gc);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        logic [NREQ-1:0] g;
        int t0, gc, gc2, gc3, ec, d0, e0, g0, bad;

        rst = 1'b1; start = 1'b0; burst_len = '0; req = '0; ack = 1'b0;
        tick(2);
        check_val("rst_grant", grant, 0);
        check_val("rst_busy",  busy,  0);
        check_val("rst_done",  done,  0);
        check_val("rst_error", error, 0);
        rst = 1'b0;
        tick(1);

        // Basic burst of 3 to requester 0
        req = 4'b0001;
        start_burst(3, t0);
        check_val("bb_busy_rise", busy, 1);
        serve("bb_g1", g, gc);
        check_val("bb_g1_val", g, 4'b0001);
        check_val("bb_g1_time", gc - t0, 2);
        serve("bb_g2", g, gc2);
        check_val("bb_g2_val", g, 4'b0001);
        check_val("bb_g2_gap", gc2 - gc, 3);
        serve("bb_g3", g, gc3);
        check_val("bb_g3_val", g, 4'b0001);
        check_val("bb_done", done, 1);
        check_val("bb_no_error", ecnt, 0);
        tick(1);
        check_val("bb_busy_fall", busy, 0);
        check_val("bb_done_cnt", dcnt, 1);

        // Round-robin from a fresh pointer
        do_reset();
        req = 4'b1011;
        start_burst(4, t0);
        serve("rr_g1", g, gc); check_val("rr_g1_val", g, 4'b0001);
        serve("rr_g2", g, gc); check_val("rr_g2_val", g, 4'b0010);
        serve("rr_g3", g, gc); check_val("rr_g3_val", g, 4'b1000);
        serve("rr_g4", g, gc); check_val("rr_g4_val", g, 4'b0001);
        check_val("rr_done", done, 1);
        tick(2);
        start_burst(1, t0);
        serve("rr_b2", g, gc); check_val("rr_b2_val", g, 4'b0010);
        check_val("rr_b2_done", done, 1);
        check_val("rr_done_cnt", dcnt, 3);

        // Zero-length burst
        tick(2);
        g0 = gcnt;
        start_burst(0, t0);
        check_val("zl_done", done, 1);
        check_val("zl_grant", grant, 0);
        tick(1);
        check_val("zl_busy_fall", busy, 0);
        check_val("zl_no_grant", gcnt - g0, 0);

        // Start while busy is ignored
        tick(2);
        req = 4'b0001;
        start_burst(2, t0);
        wait_grant("is_g1", g, gc);
        @(negedge clk);
        ack = 1'b1; start = 1'b1; burst_len = 4'd1;
        @(negedge clk);
        ack = 1'b0; start = 1'b0;
        check_val("is_no_done", done, 0);
        check_val("is_busy", busy, 1);
        serve("is_g2", g, gc);
        check_val("is_g2_val", g, 4'b0001);
        check_val("is_done", done, 1);

        // Timeout with no ack
        tick(2);
        d0 = dcnt; e0 = ecnt;
        start_burst(2, t0);
        wait_grant("to_g1", g, gc);
        ec = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (error) begin
                ec = cyc;
                break;
            end
        end
        check_val("to_err_time", ec - gc, 16);
        check_val("to_no_done", dcnt - d0, 0);
        tick(1);
        check_val("to_busy_fall", busy, 0);
        check_val("to_err_cnt", ecnt - e0, 1);

        // Ack on the last allowed cycle wins over the timeout
        tick(2);
        e0 = ecnt;
        start_burst(2, t0);
        wait_grant("a15_g1", g, gc);
        repeat (15) @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_val("a15_no_error", error, 0);
        check_val("a15_busy", busy, 1);
        serve("a15_g2", g, gc2);
        check_val("a15_g2_time", gc2 - gc, 17);
        check_val("a15_done", done, 1);
        check_val("a15_err_cnt", ecnt - e0, 0);

        // Ack during the grant cycle is not counted
        tick(2);
        start_burst(1, t0);
        wait_grant("gc_g1", g, gc);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        @(negedge clk);
        check_val("gc_no_done", done, 0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_val("gc_done", done, 1);

        // Ack held for 3 cycles counts once
        tick(2);
        start_burst(2, t0);
        wait_grant("ah_g1", g, gc);
        @(negedge clk);
        ack = 1'b1;
        tick(2);
        check_val("ah_grant2", grant, 4'b0001);
        @(negedge clk);
        ack = 1'b0;
        check_val("ah_no_done", done, 0);
        check_val("ah_no_error", error, 0);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check_val("ah_done", done, 1);

        // No requests in ARB: wait indefinitely without error
        tick(2);
        req = 4'b0000;
        start_burst(1, t0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (grant != '0 || error) bad++;
        end
        check_val("nr_quiet", bad, 0);
        check_val("nr_busy", busy, 1);
        req = 4'b0001;
        serve("nr_g1", g, gc);
        check_val("nr_done", done, 1);

        // Reset in WAIT after the 2nd of 4 grants
        tick(2);
        req = 4'b1111;
        start_burst(4, t0);
        serve("mr_g1", g, gc);
        wait_grant("mr_g2", g, gc2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d0 = dcnt; e0 = ecnt;
        check_val("mr_grant", grant, 0);
        check_val("mr_busy",  busy,  0);
        check_val("mr_done",  done,  0);
        check_val("mr_error", error, 0);
        tick(5);
        check_val("mr_no_pulse", (dcnt - d0) + (ecnt - e0), 0);
        start_burst(1, t0);
        serve("mr_n1", g, gc);
        check_val("mr_n1_val", g, 4'b0001);
        check_val("mr_n1_done", done, 1);

        tick(2);
        check_val("inv_consec_grant", consec, 0);
        check_val("inv_done_error", both, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
